// File: rtl/tile_line_renderer.sv
// Tile-mode scanline renderer: walks the tile map and pattern RAMs for one display line and
// streams palette-resolved pixels, MSB-first within each pattern byte, into one line RAM bank.
module tile_line_renderer #(
    parameter int unsigned MAP_COLS_LOG2 = 6,
    parameter int unsigned MAP_ROWS_LOG2 = 6,
    parameter int unsigned TILE_LOG2     = 3,
    parameter int unsigned BPP           = 2,
    parameter int unsigned LINE_LOG2     = 9,
    parameter int unsigned COLOR_WIDTH   = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   line_start,
    input  logic [MAP_ROWS_LOG2+TILE_LOG2-1:0]     line_y,
    input  logic                                   line_bank,
    input  logic [MAP_COLS_LOG2+TILE_LOG2-1:0]     scroll_x,
    input  logic [MAP_ROWS_LOG2+TILE_LOG2-1:0]     scroll_y,
    output logic [MAP_ROWS_LOG2+MAP_COLS_LOG2-1:0] map_addr,
    input  logic [7:0]                             map_data,
    output logic [2*TILE_LOG2+$clog2(BPP)+4:0]     pat_addr,
    input  logic [7:0]                             pat_data,
    input  logic                                   pal_we,
    input  logic [BPP-1:0]                         pal_idx,
    input  logic [COLOR_WIDTH-1:0]                 pal_din,
    output logic                                   lw_en,
    output logic [LINE_LOG2:0]                     lw_addr,
    output logic [COLOR_WIDTH-1:0]                 lw_data,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   overrun,
    input  logic                                   overrun_clr
);

    localparam int unsigned YW       = MAP_ROWS_LOG2 + TILE_LOG2;
    localparam int unsigned XW       = MAP_COLS_LOG2 + TILE_LOG2;
    localparam int unsigned BPP_LOG2 = $clog2(BPP);
    localparam int unsigned PPB_LOG2 = 3 - BPP_LOG2;
    localparam int unsigned PPB      = 1 << PPB_LOG2;
    localparam int unsigned WW       = TILE_LOG2 + BPP_LOG2 - 3;
    localparam int unsigned PAW      = 8 + TILE_LOG2 + WW;
    localparam int unsigned TILE_PX  = 1 << TILE_LOG2;
    localparam int unsigned PAL_N    = 1 << BPP;
    localparam logic [LINE_LOG2-1:0] LAST_X = LINE_LOG2'((1 << LINE_LOG2) - 1);

    typedef enum logic [2:0] {StIdle, StMap, StMapW, StPatW, StEmit} state_t;

    state_t                 state_q;
    logic [YW-1:0]          ey_q;
    logic [XW-1:0]          ex_q;
    logic [XW-1:0]          ex_nxt;
    logic                   bank_q;
    logic [LINE_LOG2-1:0]   x_q;
    logic [7:0]             pat_q;
    logic                   done_q;
    logic                   overrun_q;
    logic [COLOR_WIDTH-1:0] pal_q [PAL_N];

    logic [XW-1:0]          pix_in_byte;
    logic [7:0]             shamt;
    logic [BPP-1:0]         pix_idx;
    logic [PAW-1:0]         word;
    logic                   byte_end;

    assign ex_nxt      = ex_q + 1'b1;
    assign byte_end    = (ex_nxt & XW'(PPB - 1)) == '0;
    assign pix_in_byte = ex_q & XW'(PPB - 1);
    // Pixel 0 of a byte sits in the top BPP bits.
    assign shamt       = 8'((PPB - 1 - 32'(pix_in_byte)) * BPP);
    assign pix_idx     = BPP'(pat_q >> shamt);
    assign word        = PAW'((ex_q & XW'(TILE_PX - 1)) >> PPB_LOG2);

    assign map_addr = {ey_q[YW-1:TILE_LOG2], ex_q[XW-1:TILE_LOG2]};

    // Pattern address is formed straight from the map RAM output to keep the fetch at 3 cycles.
    assign pat_addr = (state_q == StMapW)
                    ? ((PAW'(map_data) << (TILE_LOG2 + WW))
                       | (PAW'(ey_q & YW'(TILE_PX - 1)) << WW)
                       | word)
                    : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            ey_q      <= '0;
            ex_q      <= '0;
            bank_q    <= 1'b0;
            x_q       <= '0;
            pat_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (line_start && state_q != StIdle) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr) begin
                overrun_q <= 1'b0;
            end

            if (line_start) begin
                ey_q    <= line_y + scroll_y;
                ex_q    <= scroll_x;
                bank_q  <= line_bank;
                x_q     <= '0;
                state_q <= StMap;
            end else begin
                case (state_q)
                    StIdle: state_q <= StIdle;
                    StMap:  state_q <= StMapW;
                    StMapW: state_q <= StPatW;
                    StPatW: begin
                        pat_q   <= pat_data;
                        state_q <= StEmit;
                    end
                    StEmit: begin
                        x_q  <= x_q + 1'b1;
                        ex_q <= ex_nxt;
                        if (x_q == LAST_X) begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end else if (byte_end) begin
                            state_q <= StMap;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < PAL_N; i++) begin
                pal_q[i] <= '0;
            end
        end else if (pal_we) begin
            pal_q[pal_idx] <= pal_din;
        end
    end

    always_comb begin
        lw_en   = (state_q == StEmit);
        lw_addr = '0;
        lw_data = '0;
        if (lw_en) begin
            lw_addr = {bank_q, x_q};
            lw_data = pal_q[pix_idx];
        end
        busy    = (state_q != StIdle);
        done    = done_q;
        overrun = overrun_q;
    end

endmodule

// File: tb/tb_tile_line_renderer.sv
// Scoreboard bench for tile_line_renderer at default parameters: expected line RAM writes are
// queued at line start and popped by an independent write monitor.
module tb_tile_line_renderer;

    logic       clk = 1'b0;
    logic       rst;
    logic       line_start, line_bank, pal_we, overrun_clr;
    logic [8:0] line_y, scroll_x, scroll_y;
    logic [11:0] map_addr, pat_addr;
    logic [7:0] map_data, pat_data;
    logic [1:0] pal_idx;
    logic [7:0] pal_din;
    logic       lw_en;
    logic [9:0] lw_addr;
    logic [7:0] lw_data;
    logic       busy, done, overrun;

    always #5 clk = ~clk;

    tile_line_renderer dut (
        .clk(clk), .rst(rst), .line_start(line_start), .line_y(line_y), .line_bank(line_bank),
        .scroll_x(scroll_x), .scroll_y(scroll_y), .map_addr(map_addr), .map_data(map_data),
        .pat_addr(pat_addr), .pat_data(pat_data), .pal_we(pal_we), .pal_idx(pal_idx),
        .pal_din(pal_din), .lw_en(lw_en), .lw_addr(lw_addr), .lw_data(lw_data), .busy(busy),
        .done(done), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    logic [7:0] map_mem [4096];
    logic [7:0] pat_mem [4096];
    logic [7:0] pal_m [4];

    always @(posedge clk) begin
        map_data <= map_mem[map_addr];
        pat_data <= pat_mem[pat_addr];
    end

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    int         n_vec = 0;
    int         n_err = 0;
    int         n_wr = 0;
    int         n_done = 0;
    int         d0;
    logic [11:0] seen_map_addr, seen_pat_addr;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (done) n_done++;
            if (lw_en) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required none",
                             lw_addr, lw_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("lw_addr", lw_addr, mon_e.addr);
                    check("lw_data", lw_data, mon_e.data);
                end
            end
        end
    end

    task automatic push_table(input logic bank, input logic [7:0] c0, input logic [7:0] c1,
                              input logic [7:0] c2, input logic [7:0] c3);
        for (int x = 0; x < 512; x++) begin
            wr_t e;
            e.addr = {bank, 9'(x)};
            case (x % 4)
                0:       e.data = c0;
                1:       e.data = c1;
                2:       e.data = c2;
                default: e.data = c3;
            endcase
            exp_q.push_back(e);
        end
    endtask

    // Reference pixel: 64x64 map, 8x8 tiles, 2 bytes per tile row, 4 pixels per byte MSB-first.
    function automatic logic [7:0] ref_px(input int ly, input int sy, input int sx, input int x);
        int ey, ex, tile, b, idx;
        ey   = (ly + sy) % 512;
        ex   = (sx + x) % 512;
        tile = map_mem[(ey / 8) * 64 + ex / 8];
        b    = pat_mem[tile * 16 + (ey % 8) * 2 + (ex / 4) % 2];
        idx  = (b >> (6 - 2 * (ex % 4))) % 4;
        return pal_m[idx];
    endfunction

    task automatic load_pal(input int idx, input logic [7:0] val);
        pal_idx = 2'(idx);
        pal_din = val;
        pal_we  = 1'b1;
        @(posedge clk); #1;
        pal_we  = 1'b0;
        pal_m[idx] = val;
    endtask

    task automatic start_line(input logic bank, input int ly, input int sy, input int sx);
        line_bank  = bank;
        line_y     = 9'(ly);
        scroll_y   = 9'(sy);
        scroll_x   = 9'(sx);
        line_start = 1'b1;
        @(posedge clk); #1;
        line_start = 1'b0;
    endtask

    // Entered at the line's first busy cycle; counts busy cycles and first-write latency.
    task automatic finish_line(input int exp_busy);
        int cyc, first, dd;
        cyc   = 0;
        first = 0;
        dd    = n_done;
        n_wr  = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 0) seen_map_addr = map_addr;
            if (i == 1) seen_pat_addr = pat_addr;
            if (!busy) break;
            if (lw_en && first == 0) first = i + 1;
            cyc++;
        end
        check("busy_cycles", cyc, exp_busy);
        check("first_write_latency", first, 4);
        check("done_at_end", done, 1);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("done_count", n_done - dd, 1);
        check("write_count", n_wr, 512);
        check("queue_empty", exp_q.size(), 0);
    endtask

    task automatic run_line(input logic bank, input int ly, input int sy, input int sx,
                            input int exp_busy);
        start_line(bank, ly, sy, sx);
        finish_line(exp_busy);
    endtask

    initial begin
        rst = 1'b1; line_start = 1'b0; line_bank = 1'b0; pal_we = 1'b0; overrun_clr = 1'b0;
        line_y = '0; scroll_x = '0; scroll_y = '0; pal_idx = '0; pal_din = '0;
        for (int i = 0; i < 4096; i++) begin
            map_mem[i] = 8'd1;
            pat_mem[i] = 8'hE4;
        end
        for (int i = 0; i < 4; i++) pal_m[i] = 8'h00;
        repeat (3) @(posedge clk); #1;
        check("rst_lw_en", lw_en, 0);
        check("rst_lw_addr", lw_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_map_addr", map_addr, 0);
        check("rst_pat_addr", pat_addr, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        // Listed high index first: E4 = pixels with idx 3,2,1,0.
        load_pal(0, 8'hE0);
        load_pal(1, 8'h1C);
        load_pal(2, 8'h03);
        load_pal(3, 8'h00);

        // Unscrolled line of tile 1.
        push_table(1'b0, 8'h00, 8'h03, 8'h1C, 8'hE0);
        run_line(1'b0, 0, 0, 0, 896);

        // Fine X scroll: 1-pixel first byte, 3-pixel last byte, column 63 distinct.
        for (int i = 0; i < 4096; i++) map_mem[i] = (i % 64 == 63) ? 8'd2 : 8'd1;
        for (int i = 0; i < 16; i++) pat_mem[32 + i] = 8'h1B;
        for (int x = 0; x < 512; x++) exp_q.push_back({1'b0, 9'(x), ref_px(0, 0, 3, x)});
        run_line(1'b0, 0, 0, 3, 899);

        // Vertical wrap: 500+20 -> ey 8 -> map row 1, tile row 0.
        for (int i = 0; i < 4096; i++) map_mem[i] = (i / 64 == 1) ? 8'd3 : 8'd1;
        for (int i = 0; i < 16; i++) pat_mem[48 + i] = (i < 2) ? 8'h1B : 8'hFF;
        push_table(1'b1, 8'hE0, 8'h1C, 8'h03, 8'h00);
        run_line(1'b1, 500, 20, 0, 896);
        check("map_addr_row1", seen_map_addr, 64);
        check("pat_addr_tile3_row0", seen_pat_addr, 48);

        // Restart while busy, with a simultaneous clear that must lose.
        push_table(1'b0, 8'h00, 8'h03, 8'h1C, 8'hE0);
        n_wr = 0;
        start_line(1'b0, 0, 0, 0);
        repeat (99) @(posedge clk);
        #1;
        line_y      = 9'd8;
        line_start  = 1'b1;
        overrun_clr = 1'b1;
        @(posedge clk); #1;
        line_start  = 1'b0;
        overrun_clr = 1'b0;
        check("overrun_set_priority", overrun, 1);
        check("abandoned_line_writes", n_wr, 56);
        exp_q.delete();
        push_table(1'b0, 8'hE0, 8'h1C, 8'h03, 8'h00);
        finish_line(896);
        check("overrun_sticky", overrun, 1);
        overrun_clr = 1'b1;
        @(posedge clk); #1;
        overrun_clr = 1'b0;
        check("overrun_cleared", overrun, 0);

        // Palette entry 2 rewritten while pixel 101 (idx 2) is on the write port.
        for (int x = 0; x < 512; x++) begin
            logic [7:0] c;
            case (x % 4)
                0:       c = 8'h00;
                1:       c = (x > 101) ? 8'hFF : 8'h03;
                2:       c = 8'h1C;
                default: c = 8'hE0;
            endcase
            exp_q.push_back({1'b0, 9'(x), c});
        end
        start_line(1'b0, 0, 0, 0);
        fork
            finish_line(896);
            begin
                int hit;
                hit = 0;
                for (int i = 0; i < 2000; i++) begin
                    @(negedge clk);
                    if (lw_en && lw_addr[8:0] == 9'd100) begin
                        hit = 1;
                        break;
                    end
                end
                check("pal_trigger_found", hit, 1);
                @(posedge clk); #1;
                pal_idx = 2'd2;
                pal_din = 8'hFF;
                pal_we  = 1'b1;
                @(posedge clk); #1;
                pal_we  = 1'b0;
            end
        join
        pal_m[2] = 8'hFF;

        // Reset in the middle of an EMIT run.
        push_table(1'b0, 8'h00, 8'hFF, 8'h1C, 8'hE0);
        n_wr = 0;
        start_line(1'b0, 0, 0, 0);
        repeat (59) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_lw_en", lw_en, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("writes_before_reset", n_wr, 32);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        d0 = n_done;
        repeat (1000) @(posedge clk);
        #1;
        check("no_done_after_reset", n_done - d0, 0);
        check("overrun_after_reset", overrun, 0);

        // Palette was cleared by reset.
        for (int i = 0; i < 4; i++) pal_m[i] = 8'h00;
        push_table(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        run_line(1'b0, 0, 0, 0, 896);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
